// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef logic port_t;
  localparam port_t PORT_D = 1'b0;  // data cache
  localparam port_t PORT_I = 1'b1;  // instruction cache

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-side ports and the shared main-memory port.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wd0, wd1;
  logic [DATA_W-1:0] rd0, rd1;
  logic              done0, done1;
  logic              gnt0, gnt1;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic              mem_ready;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd, mem_ready,
    output rd0, rd1, done0, done1, gnt0, gnt1, mem_req, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd, mem_ready,
    input  rd0, rd1, done0, done1, gnt0, gnt1, mem_req, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/arb_grant_select.sv
// Combinational winner pick between the two ports.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the port not served last; otherwise port 0 wins.
module arb_grant_select
  import mem_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last,
  output port_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (req0 && req1) winner = (last == PORT_D) ? PORT_I : PORT_D;
    else if (req1)    winner = PORT_I;
    else              winner = PORT_D;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    if (!req0 && req1) winner = PORT_I;
    else               winner = PORT_D;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a data-cache and an instruction-cache port onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed port-0 priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  state_t            state;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              done0_q, done1_q;
  logic              gnt0_q, gnt1_q;

  port_t winner;
  port_t last_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_t last_q;
  assign last_port = last_q;
`else
  assign last_port = PORT_I;
`endif

  arb_grant_select u_grant_select (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_port),
    .winner (winner)
  );

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // rd0/rd1 are reset too so a port never observes an undefined read value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= PORT_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt0_q     <= (winner == PORT_D);
            gnt1_q     <= (winner == PORT_I);
            mem_req_q  <= 1'b1;
            mem_we_q   <= (winner == PORT_I) ? bus.we1   : bus.we0;
            mem_addr_q <= (winner == PORT_I) ? bus.addr1 : bus.addr0;
            mem_wd_q   <= (winner == PORT_I) ? bus.wd1   : bus.wd0;
            state      <= MEM;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= winner;
`endif
          end
        end
        MEM: begin
          // Completion is tracked by the grant, not by reqN, so a dropped request still finishes.
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              if (gnt1_q) rd1_q <= bus.mem_rd;
              else        rd0_q <= bus.mem_rd;
            end
            done0_q <= gnt0_q;
            done1_q <= gnt1_q;
            state   <= RESP;
          end
        end
        RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.rd0      = rd0_q;
  assign bus.rd1      = rd1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;

endmodule
